// File: rtl/memory_access.sv
// memory_access: M stage of the pipeline. Registers execute results, resolves the
// CBZ select, and performs a single LDUR/STUR over a req/ack data-memory bus with
// a bounded wait. Optional build macro: MISALIGN_CHECK_EN (reject non-8-byte-aligned
// accesses without touching the bus).
module memory_access #(
  parameter int N           = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_M,
  input  logic         memRead_M,
  input  logic         memWrite_M,
  input  logic         Branch_M,
  input  logic         zero_M,
  input  logic [N-1:0] aluResult_M,
  input  logic [N-1:0] writeData_M,
  input  logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranchOut_M,
  output logic [N-1:0] aluOut_M,
  output logic [N-1:0] readData_M,
  output logic         busy_M,
  output logic         done_M,
  output logic         err_M,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_store;
  logic [N-1:0]       r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_start;
  logic               w_mem;
  logic               w_misalign;
  logic               w_expire;

  // start_M is only honoured from IDLE; any other cycle it is dropped
  assign w_start = (r_state == S_IDLE) && start_M;
  assign w_mem   = memRead_M | memWrite_M;

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = w_mem && (aluResult_M[2:0] != 3'b000);
`else
  assign w_misalign = 1'b0;
`endif

  // r_cnt holds the number of REQ cycles already completed, so the last allowed
  // REQ cycle is the one where it equals TIMEOUT_CYC-1
  assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // State register; async reset returns to IDLE so dm_req drops immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and bus/handshake outputs; ack takes priority over expiry
  always_comb begin
    w_next   = r_state;
    busy_M   = 1'b0;
    done_M   = 1'b0;
    err_M    = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = aluOut_M;
    dm_wdata = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (start_M) begin
          if (!w_mem)          w_next = S_DONE;
          else if (w_misalign) w_next = S_ERR;
          else                 w_next = S_REQ;
        end
      end
      S_REQ: begin
        busy_M = 1'b1;
        dm_req = 1'b1;
        dm_we  = r_store;
        if (dm_ack)        w_next = S_DONE;
        else if (w_expire) w_next = S_ERR;
      end
      S_DONE: begin
        busy_M = 1'b1;
        done_M = 1'b1;
        w_next = S_IDLE;
      end
      S_ERR: begin
        busy_M = 1'b1;
        done_M = 1'b1;
        err_M  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Wait counter: cleared on every entry to REQ, counts REQ cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 r_cnt <= '0;
    else if (w_start)           r_cnt <= '0;
    else if (r_state == S_REQ)  r_cnt <= r_cnt + 1'b1;
  end

  // Latch execute results at accepted start; capture load data on ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCSrc_M       <= 1'b0;
      PCBranchOut_M <= '0;
      aluOut_M      <= '0;
      r_store       <= 1'b0;
      r_wdata       <= '0;
      readData_M    <= '0;
    end else begin
      if (w_start) begin
        PCSrc_M       <= Branch_M & zero_M;
        PCBranchOut_M <= PCBranch_M;
        aluOut_M      <= aluResult_M;
        r_store       <= memWrite_M;   // store wins when both read and write are set
        r_wdata       <= writeData_M;
      end
      if ((r_state == S_REQ) && dm_ack && !r_store)
        readData_M <= dm_rdata;
    end
  end

endmodule
